// File: rtl/mcu_dmem_map_pkg.sv
// Address map, register-select encoding and CTRL bit positions shared by the
// data-memory subsystem and its timer.
package mcu_dmem_map_pkg;

  localparam logic [31:0] RAM_BASE         = 32'h0000_0000;
  localparam logic [31:0] PERIPH_BASE      = 32'h8000_0000;
  localparam logic [31:0] GPIO_OUT_OFS     = 32'h0000_0000;
  localparam logic [31:0] GPIO_IN_OFS      = 32'h0000_0004;
  localparam logic [31:0] TIMER_CTRL_OFS   = 32'h0000_0010;
  localparam logic [31:0] TIMER_LOAD_OFS   = 32'h0000_0014;
  localparam logic [31:0] TIMER_COUNT_OFS  = 32'h0000_0018;
  localparam logic [31:0] TIMER_STATUS_OFS = 32'h0000_001C;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_AUTO  = 1;
  localparam int CTRL_IRQEN = 2;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_GPIO_OUT,
    SEL_GPIO_IN,
    SEL_TCTRL,
    SEL_TLOAD,
    SEL_TCOUNT,
    SEL_TSTATUS
  } regSel_e;

  // Word-address match against the peripheral window; anything else is unmapped.
  function automatic regSel_e periphSel(input logic [29:0] wordAddr);
    case (wordAddr)
      30'((PERIPH_BASE + GPIO_OUT_OFS) >> 2):     return SEL_GPIO_OUT;
      30'((PERIPH_BASE + GPIO_IN_OFS) >> 2):      return SEL_GPIO_IN;
      30'((PERIPH_BASE + TIMER_CTRL_OFS) >> 2):   return SEL_TCTRL;
      30'((PERIPH_BASE + TIMER_LOAD_OFS) >> 2):   return SEL_TLOAD;
      30'((PERIPH_BASE + TIMER_COUNT_OFS) >> 2):  return SEL_TCOUNT;
      30'((PERIPH_BASE + TIMER_STATUS_OFS) >> 2): return SEL_TSTATUS;
      default:                                    return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mcu_dmem_timer.sv
// Down-counting timer: CTRL/LOAD/COUNT/expired registers with one-shot or
// auto-reload behaviour and a level interrupt.
module mcu_dmem_timer
  import mcu_dmem_map_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ctrlWe,
  input  logic        loadWe,
  input  logic        statusWe,
  input  logic [31:0] wdata,
  output logic [2:0]  ctrl,
  output logic [31:0] load,
  output logic [31:0] count,
  output logic        expired,
  output logic        timerIrq
);

  logic [2:0]  ctrlNext;
  logic [31:0] countNext;
  logic        expiredNext;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    ctrlNext    = ctrl;
    countNext   = count;
    expiredNext = expired;

    if (statusWe && wdata[0]) expiredNext = 1'b0;

    // Expiry is evaluated after the clear so a same-cycle set wins.
    if (ctrl[CTRL_EN]) begin
      if (count != 32'd0) begin
        countNext = count - 32'd1;
      end else begin
        expiredNext = 1'b1;
        if (ctrl[CTRL_AUTO]) countNext = load;
        else                 ctrlNext[CTRL_EN] = 1'b0;
      end
    end

    // CPU writes override the hardware reload and one-shot enable clear.
    if (ctrlWe) ctrlNext  = wdata[2:0];
    if (loadWe) countNext = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      ctrl    <= '0;
      load    <= '0;
      count   <= '0;
      expired <= 1'b0;
    end else begin
      ctrl    <= ctrlNext;
      count   <= countNext;
      expired <= expiredNext;
      if (loadWe) load <= wdata;
    end
  end

  assign timerIrq = expired & ctrl[CTRL_IRQEN];

endmodule

// File: rtl/mcu_dmem_subsys.sv
// MEM-stage data-memory subsystem: word RAM, GPIO with input synchronizer and a
// timer, behind a combinational read mux.
module mcu_dmem_subsys
  import mcu_dmem_map_pkg::*;
#(
  parameter int RAM_WORDS = 1024,
  parameter int GPIO_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       dmem_addr,
  input  logic [31:0]       dmem_wdata,
  input  logic              dmem_we,
  output logic [31:0]       dmem_rdata,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [29:0]       wordAddr;
  logic [AW-1:0]     ramIdx;
  logic              unusedAddrBits;
  regSel_e           sel;
  logic [31:0]       mem [RAM_WORDS];
  logic [GPIO_W-1:0] gpioMeta;
  logic [GPIO_W-1:0] gpioSync;
  logic [2:0]        tCtrl;
  logic [31:0]       tLoad;
  logic [31:0]       tCount;
  logic              tExpired;

  assign wordAddr       = dmem_addr[31:2];
  assign ramIdx         = dmem_addr[AW+1:2];
  assign unusedAddrBits = ^dmem_addr[1:0];

  always_comb begin
    if (wordAddr[29:AW] == RAM_BASE[31:AW+2]) sel = SEL_RAM;
    else                                      sel = periphSel(wordAddr);
  end

  // NOTE: the RAM array has no reset; only its write port is clocked.
  always_ff @(posedge clk) begin
    if (dmem_we && sel == SEL_RAM) mem[ramIdx] <= dmem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_out <= '0;
      gpioMeta <= '0;
      gpioSync <= '0;
    end else begin
      gpioMeta <= gpio_in;
      gpioSync <= gpioMeta;
      if (dmem_we && sel == SEL_GPIO_OUT) gpio_out <= dmem_wdata[GPIO_W-1:0];
    end
  end

  mcu_dmem_timer uTimer (
    .clk      (clk),
    .rst_n    (rst_n),
    .ctrlWe   (dmem_we && sel == SEL_TCTRL),
    .loadWe   (dmem_we && sel == SEL_TLOAD),
    .statusWe (dmem_we && sel == SEL_TSTATUS),
    .wdata    (dmem_wdata),
    .ctrl     (tCtrl),
    .load     (tLoad),
    .count    (tCount),
    .expired  (tExpired),
    .timerIrq (timer_irq)
  );

  always_comb begin
    dmem_rdata = '0;
    case (sel)
      SEL_RAM:      dmem_rdata = mem[ramIdx];
      SEL_GPIO_OUT: dmem_rdata[GPIO_W-1:0] = gpio_out;
      SEL_GPIO_IN:  dmem_rdata[GPIO_W-1:0] = gpioSync;
      SEL_TCTRL:    dmem_rdata[2:0] = tCtrl;
      SEL_TLOAD:    dmem_rdata = tLoad;
      SEL_TCOUNT:   dmem_rdata = tCount;
      SEL_TSTATUS:  dmem_rdata[0] = tExpired;
      default:      dmem_rdata = '0;
    endcase
  end

endmodule
